// File: rtl/uart_16550_fifo_ctrl_if.sv
// Port bundle for one UART 16550 FIFO instance (Tx or Rx direction).
// The FIFO itself connects through the slave modport; the client uses master.
interface uart_16550_fifo_ctrl_if #(
    parameter int DW = 11,
    parameter int AW = 9
);
    logic          Flush_i;
    logic          Push_i;
    logic [DW-1:0] DAT_i;
    logic          Pop_i;
    logic [DW-1:0] DAT_o;
    logic [AW:0]   Level_o;
    logic          Empty_o;
    logic          Full_o;
    logic [1:0]    Trig_Sel_i;
    logic          Trig_o;
    logic          Overrun_o;
    logic          Ovr_Clr_i;
    logic          Err_In_FIFO_o;
    logic          Timeout_o;

    modport slave (
        input  Flush_i, Push_i, DAT_i, Pop_i, Trig_Sel_i, Ovr_Clr_i,
        output DAT_o, Level_o, Empty_o, Full_o, Trig_o, Overrun_o, Err_In_FIFO_o, Timeout_o
    );

    modport master (
        output Flush_i, Push_i, DAT_i, Pop_i, Trig_Sel_i, Ovr_Clr_i,
        input  DAT_o, Level_o, Empty_o, Full_o, Trig_o, Overrun_o, Err_In_FIFO_o, Timeout_o
    );
endinterface

// File: rtl/uart_16550_fifo_ctrl.sv
// First-word fall-through FIFO with overrun, trigger level and error-in-FIFO tracking.
// Optional Rx character timeout is built only when UART_FIFO_TIMEOUT_EN is defined.
module uart_16550_fifo_ctrl #(
    parameter int DW      = 11,
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int ERR_LSB = 8,
    parameter int ERR_W   = 3,
    parameter int TO_W    = 16,
    parameter int TO_CYC  = 40000
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    uart_16550_fifo_ctrl_if.slave  fifo_if
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    if (((1 << AW) != DEPTH) || (DEPTH < 4)) begin : g_bad_depth
        $error("DEPTH must equal 2**AW and be at least 4");
    end
    if (64'(TO_CYC) >= (64'd1 << TO_W)) begin : g_bad_to_cyc
        $error("TO_CYC must fit in TO_W bits");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovr_q, ovr_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [AW:0]   trig_lvl;
    logic [DW-1:0] head;
    logic          push_ok, pop_ok, ovr_ev;
    logic          err_in, err_out;

    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = fifo_if.Pop_i & ~empty_q;
    // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
    assign push_ok = fifo_if.Push_i & (~full_q | pop_ok);
    assign ovr_ev  = fifo_if.Push_i & full_q & ~pop_ok;

    if (ERR_W > 0) begin : g_err
        assign err_in  = push_ok & (|fifo_if.DAT_i[ERR_LSB +: ERR_W]);
        assign err_out = pop_ok & (|head[ERR_LSB +: ERR_W]);
    end else begin : g_no_err
        assign err_in  = 1'b0;
        assign err_out = 1'b0;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        empty_d   = empty_q;
        full_d    = full_q;
        ovr_d     = ovr_q;
        err_cnt_d = err_cnt_q;
        if (fifo_if.Flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            empty_d   = 1'b1;
            full_d    = 1'b0;
            ovr_d     = 1'b0;
            err_cnt_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            empty_d = (level_d == '0);
            full_d  = (level_d == LVL_FULL);
            // Set beats clear when a new overrun coincides with Ovr_Clr_i.
            if (ovr_ev)                 ovr_d = 1'b1;
            else if (fifo_if.Ovr_Clr_i) ovr_d = 1'b0;
            case ({err_in, err_out})
                2'b10:   err_cnt_d = err_cnt_q + 1'b1;
                2'b01:   err_cnt_d = err_cnt_q - 1'b1;
                default: err_cnt_d = err_cnt_q;
            endcase
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (push_ok && !fifo_if.Flush_i) mem_q[wr_ptr_q] <= fifo_if.DAT_i;
    end

    always_comb begin
        case (fifo_if.Trig_Sel_i)
            2'b00:   trig_lvl = (AW+1)'(1);
            2'b01:   trig_lvl = (AW+1)'(DEPTH / 4);
            2'b10:   trig_lvl = (AW+1)'(DEPTH / 2);
            default: trig_lvl = (AW+1)'(DEPTH - 2);
        endcase
    end

`ifdef UART_FIFO_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYC);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (fifo_if.Push_i || fifo_if.Pop_i || fifo_if.Flush_i || empty_q) to_cnt_d = '0;
        else if (to_cnt_q != TO_LIM)                                        to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) to_cnt_q <= '0;
        else           to_cnt_q <= to_cnt_d;
    end

    assign fifo_if.Timeout_o = (to_cnt_q == TO_LIM);
`else
    assign fifo_if.Timeout_o = 1'b0;
`endif

    assign fifo_if.DAT_o         = empty_q ? '0 : head;
    assign fifo_if.Level_o       = level_q;
    assign fifo_if.Empty_o       = empty_q;
    assign fifo_if.Full_o        = full_q;
    assign fifo_if.Trig_o        = (level_q >= trig_lvl);
    assign fifo_if.Overrun_o     = ovr_q;
    assign fifo_if.Err_In_FIFO_o = (err_cnt_q != '0);

endmodule

// File: tb/tb_uart_16550_fifo_ctrl.sv
// Directed bench for uart_16550_fifo_ctrl (DEPTH=512, DW=11); timeout steps
// are exercised only when UART_FIFO_TIMEOUT_EN is defined.
module tb_uart_16550_fifo_ctrl;
    localparam int DW = 11;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_16550_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    uart_16550_fifo_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .ERR_LSB(8), .ERR_W(3), .TO_W(16), .TO_CYC(10)
    ) dut (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst),
        .fifo_if   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.Push_i = 1'b1;
        bus.DAT_i  = d;
        tick();
        bus.Push_i = 1'b0;
    endtask

    task automatic pop();
        bus.Pop_i = 1'b1;
        tick();
        bus.Pop_i = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_d;

        rst            = 1'b1;
        bus.Flush_i    = 1'b0;
        bus.Push_i     = 1'b0;
        bus.DAT_i      = '0;
        bus.Pop_i      = 1'b0;
        bus.Trig_Sel_i = 2'b00;
        bus.Ovr_Clr_i  = 1'b0;
        tick();
        tick();

        chk("rst_level", 32'(bus.Level_o), 32'd0);
        chk("rst_empty", 32'(bus.Empty_o), 32'd1);
        chk("rst_full", 32'(bus.Full_o), 32'd0);
        chk("rst_ovr", 32'(bus.Overrun_o), 32'd0);
        chk("rst_err", 32'(bus.Err_In_FIFO_o), 32'd0);
        chk("rst_trig", 32'(bus.Trig_o), 32'd0);
        chk("rst_to", 32'(bus.Timeout_o), 32'd0);
        chk("rst_dat", 32'(bus.DAT_o), 32'd0);
        rst = 1'b0;
        tick();

        // basic push/pop with fall-through latency
        push(11'h041);
        chk("t1_dat_first", 32'(bus.DAT_o), 32'h041);
        chk("t1_lvl_first", 32'(bus.Level_o), 32'd1);
        push(11'h042);
        chk("t1_lvl", 32'(bus.Level_o), 32'd2);
        chk("t1_empty", 32'(bus.Empty_o), 32'd0);
        chk("t1_dat", 32'(bus.DAT_o), 32'h041);
        pop();
        chk("t1_pop_dat", 32'(bus.DAT_o), 32'h042);
        chk("t1_pop_lvl", 32'(bus.Level_o), 32'd1);
        pop();
        chk("t1_drain_empty", 32'(bus.Empty_o), 32'd1);
        chk("t1_drain_dat", 32'(bus.DAT_o), 32'd0);
        pop();
        chk("t1_pop_empty_lvl", 32'(bus.Level_o), 32'd0);
        chk("t1_pop_empty_ovr", 32'(bus.Overrun_o), 32'd0);

        // push and pop together while empty: push only
        bus.Pop_i = 1'b1;
        push(11'h077);
        bus.Pop_i = 1'b0;
        chk("pp_empty_lvl", 32'(bus.Level_o), 32'd1);
        chk("pp_empty_dat", 32'(bus.DAT_o), 32'h077);

        // asynchronous reset mid-operation
        push(11'h011);
        chk("mr_pre_lvl", 32'(bus.Level_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mr_lvl", 32'(bus.Level_o), 32'd0);
        chk("mr_empty", 32'(bus.Empty_o), 32'd1);
        chk("mr_dat", 32'(bus.DAT_o), 32'd0);
        rst = 1'b0;
        tick();

        // fill to full, overrun behaviour
        for (int i = 0; i < DEPTH; i++) push(DW'(i & 8'hFF));
        chk("t2_full", 32'(bus.Full_o), 32'd1);
        chk("t2_lvl", 32'(bus.Level_o), 32'd512);
        chk("t2_trig00", 32'(bus.Trig_o), 32'd1);
        bus.Trig_Sel_i = 2'b11;
        #1;
        chk("t2_trig11", 32'(bus.Trig_o), 32'd1);
        bus.Trig_Sel_i = 2'b00;
        push(11'h0FF);
        chk("t2_ovr", 32'(bus.Overrun_o), 32'd1);
        chk("t2_ovr_lvl", 32'(bus.Level_o), 32'd512);
        bus.Ovr_Clr_i = 1'b1;
        tick();
        bus.Ovr_Clr_i = 1'b0;
        chk("t2_ovr_clr", 32'(bus.Overrun_o), 32'd0);
        bus.Ovr_Clr_i = 1'b1;
        push(11'h0FF);
        bus.Ovr_Clr_i = 1'b0;
        chk("t2_set_wins", 32'(bus.Overrun_o), 32'd1);
        bus.Ovr_Clr_i = 1'b1;
        tick();
        bus.Ovr_Clr_i = 1'b0;
        chk("t2_ovr_clr2", 32'(bus.Overrun_o), 32'd0);

        // push+pop while full, then drain across the pointer wrap
        bus.Pop_i = 1'b1;
        push(11'h0AB);
        bus.Pop_i = 1'b0;
        chk("t3_lvl", 32'(bus.Level_o), 32'd512);
        chk("t3_full", 32'(bus.Full_o), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            exp_d = (k < DEPTH - 1) ? DW'((k + 1) & 8'hFF) : 11'h0AB;
            chk("t3_order", 32'(bus.DAT_o), 32'(exp_d));
            pop();
        end
        chk("t3_empty", 32'(bus.Empty_o), 32'd1);
        chk("t3_lvl0", 32'(bus.Level_o), 32'd0);

        // trigger level DEPTH/4
        bus.Trig_Sel_i = 2'b01;
        for (int i = 0; i < 127; i++) push(11'h001);
        chk("t4_lvl127", 32'(bus.Level_o), 32'd127);
        chk("t4_trig127", 32'(bus.Trig_o), 32'd0);
        push(11'h001);
        chk("t4_trig128", 32'(bus.Trig_o), 32'd1);
        bus.Trig_Sel_i = 2'b10;
        #1;
        chk("t4_trig_half", 32'(bus.Trig_o), 32'd0);
        bus.Trig_Sel_i = 2'b00;
        bus.Flush_i = 1'b1;
        tick();
        bus.Flush_i = 1'b0;
        chk("t4_flush_lvl", 32'(bus.Level_o), 32'd0);
        chk("t4_flush_trig", 32'(bus.Trig_o), 32'd0);

        // error-in-FIFO tracking and flush mid-traffic
        push(11'h3AA);
        push(11'h055);
        chk("t5_err", 32'(bus.Err_In_FIFO_o), 32'd1);
        pop();
        chk("t5_err_pop", 32'(bus.Err_In_FIFO_o), 32'd0);
        chk("t5_dat", 32'(bus.DAT_o), 32'h055);
        push(11'h123);
        chk("t5_err2", 32'(bus.Err_In_FIFO_o), 32'd1);
        chk("t5_lvl2", 32'(bus.Level_o), 32'd2);
        bus.Flush_i = 1'b1;
        bus.Pop_i   = 1'b1;
        push(11'h0EE);
        bus.Flush_i = 1'b0;
        bus.Pop_i   = 1'b0;
        chk("t5_fl_empty", 32'(bus.Empty_o), 32'd1);
        chk("t5_fl_dat", 32'(bus.DAT_o), 32'd0);
        chk("t5_fl_lvl", 32'(bus.Level_o), 32'd0);
        chk("t5_fl_err", 32'(bus.Err_In_FIFO_o), 32'd0);
        push(11'h066);
        chk("t5_after_dat", 32'(bus.DAT_o), 32'h066);
        chk("t5_after_lvl", 32'(bus.Level_o), 32'd1);
        pop();

`ifdef UART_FIFO_TIMEOUT_EN
        push(11'h033);
        for (int i = 0; i < 9; i++) tick();
        chk("t6_to_early", 32'(bus.Timeout_o), 32'd0);
        tick();
        chk("t6_to", 32'(bus.Timeout_o), 32'd1);
        tick();
        chk("t6_to_hold", 32'(bus.Timeout_o), 32'd1);
        pop();
        chk("t6_to_drop", 32'(bus.Timeout_o), 32'd0);
`else
        push(11'h033);
        for (int i = 0; i < 20; i++) tick();
        chk("t6_to_off", 32'(bus.Timeout_o), 32'd0);
        pop();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
